// File: rtl/rand32_pkg.sv
// Shared types and defaults for the rand32 requester.
// State encoding and default sizing constants.
package rand32_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int DEPTH_DEF = 4;
  localparam int CNTW_DEF  = 16;

endpackage

// File: rtl/rand32_resp_fifo.sv
// Response buffer for the rand32 requester.
// Power-of-two circular FIFO with a combinational view of the head word.
module rand32_resp_fifo
  import rand32_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [31:0]              wr_data_i,
  input  logic                     rd_en_i,
  output logic [31:0]              rd_data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr, rd;

  assign rd = rd_en_i && (cnt_q != '0);
  assign wr = wr_en_i && ((cnt_q != FULL) || rd);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (wr) wptr_d = wptr_q + 1'b1;
    if (rd) rptr_d = rptr_q + 1'b1;
    unique case ({wr, rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q] <= wr_data_i;
  end

  assign valid_o   = (cnt_q != '0);
  assign rd_data_o = valid_o ? mem_q[rptr_q] : '0;
  assign count_o   = cnt_q;

endmodule

// File: rtl/rand32_requester.sv
// Burst requester for a one-cycle-latency random word generator.
// Credit-limited issue into a response FIFO with running XOR checksum.
module rand32_requester
  import rand32_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [CNTW-1:0] COUNT,
  input  logic            GEN_DONE,
  output logic            REQ_WRITE,
  output logic            REQ_WRITE_VALID,
  input  logic [31:0]     RESP_READ,
  input  logic            RESP_READ_VALID,
  output logic [31:0]     OUT_DATA,
  output logic            OUT_VALID,
  input  logic            DEQ,
  output logic            BUSY,
  output logic            DONE,
  output logic [31:0]     CHECKSUM,
  output logic            ERR
);

  localparam int OW = $clog2(DEPTH) + 1;
  localparam logic [OW:0] CAP = (OW+1)'(DEPTH);

  state_e          state_q, state_d;
  logic [CNTW-1:0] rem_q, rem_d;
  logic            pend_q, pend_d;
  logic [31:0]     csum_q, csum_d;
  logic            err_q, err_d;
  logic            done_q, done_d;

  logic [OW-1:0]   occ;
  logic [OW:0]     need;
  logic            enq, deq_en, req, empty_nx;

  assign enq    = pend_q && RESP_READ_VALID;
  assign deq_en = DEQ && OUT_VALID;

  // Space check ignores a same-cycle pop on purpose.
  assign need = {1'b0, occ} + (OW+1)'(pend_q) + (OW+1)'(1);
  assign req  = (state_q == RUN) && (rem_q != '0)
             && GEN_DONE && (need <= CAP);

  assign empty_nx = (occ == '0)
                 || ((occ == OW'(1)) && deq_en && !enq);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    pend_d  = req;
    csum_d  = enq ? (csum_q ^ RESP_READ) : csum_q;
    err_d   = err_q | (pend_q ^ RESP_READ_VALID);
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          if (COUNT != '0) begin
            state_d = RUN;
            rem_d   = COUNT;
            csum_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (req) rem_d = rem_q - 1'b1;
        if ((rem_q == '0) && !pend_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (empty_nx) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      rem_q   <= '0;
      pend_q  <= 1'b0;
      csum_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
      csum_q  <= csum_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  rand32_resp_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i    (CLK),
    .rst_ni   (RESET),
    .wr_en_i  (enq),
    .wr_data_i(RESP_READ),
    .rd_en_i  (deq_en),
    .rd_data_o(OUT_DATA),
    .valid_o  (OUT_VALID),
    .count_o  (occ)
  );

  assign REQ_WRITE       = req;
  assign REQ_WRITE_VALID = req;
  assign BUSY            = (state_q != IDLE);
  assign DONE            = done_q;
  assign CHECKSUM        = csum_q;
  assign ERR             = err_q;

endmodule

// File: tb/tb_rand32_requester.sv
// Self-checking bench for rand32_requester: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_rand32_requester;

  localparam int DEPTH = 4;
  localparam int CNTW  = 16;

  logic            CLK = 1'b0;
  logic            RESET = 1'b0;
  logic            START = 1'b0;
  logic [CNTW-1:0] COUNT = '0;
  logic            GEN_DONE = 1'b0;
  logic            REQ_WRITE, REQ_WRITE_VALID;
  logic [31:0]     RESP_READ = '0;
  logic            RESP_READ_VALID = 1'b0;
  logic [31:0]     OUT_DATA;
  logic            OUT_VALID;
  logic            DEQ = 1'b0;
  logic            BUSY, DONE, ERR;
  logic [31:0]     CHECKSUM;

  rand32_requester #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .COUNT(COUNT),
    .GEN_DONE(GEN_DONE), .REQ_WRITE(REQ_WRITE),
    .REQ_WRITE_VALID(REQ_WRITE_VALID), .RESP_READ(RESP_READ),
    .RESP_READ_VALID(RESP_READ_VALID), .OUT_DATA(OUT_DATA),
    .OUT_VALID(OUT_VALID), .DEQ(DEQ), .BUSY(BUSY), .DONE(DONE),
    .CHECKSUM(CHECKSUM), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 running, 2 draining.
  int          m_mode = 0;
  int          m_rem = 0;
  int          m_pend = 0;
  logic [31:0] m_q[$];
  logic [31:0] m_csum = '0;
  bit          m_err = 0;
  bit          m_done = 0;
  bit          mr;
  int          orem, opend;

  function automatic bit m_req();
    return (m_mode == 1) && (m_rem > 0) && (GEN_DONE == 1'b1)
        && (m_q.size() + m_pend + 1 <= DEPTH);
  endfunction

  initial forever begin
    @(posedge CLK or negedge RESET);
    if (!RESET) begin
      m_mode = 0; m_rem = 0; m_pend = 0; m_q.delete();
      m_csum = '0; m_err = 0; m_done = 0;
    end else begin
      mr = m_req();
      orem = m_rem;
      opend = m_pend;
      if (DEQ && m_q.size() > 0) void'(m_q.pop_front());
      if (m_pend == 1 && RESP_READ_VALID) begin
        m_q.push_back(RESP_READ);
        m_csum ^= RESP_READ;
      end
      if ((m_pend == 1) != (RESP_READ_VALID == 1'b1)) m_err = 1;
      m_done = 0;
      case (m_mode)
        0: if (START) begin
          if (COUNT > 0) begin
            m_mode = 1; m_rem = int'(COUNT); m_csum = '0;
          end else m_done = 1;
        end
        1: begin
          if (mr) m_rem--;
          if (orem == 0 && opend == 0) m_mode = 2;
        end
        default: if (m_q.size() == 0) begin
          m_mode = 0; m_done = 1;
        end
      endcase
      m_pend = mr ? 1 : 0;
    end
  end

  // Logs for the directed checks.
  int          cyc = 0;
  int          req_cnt = 0;
  int          done_cnt = 0;
  int          req_cyc[$];
  logic [31:0] pops[$];
  logic [31:0] exp_q[$];

  initial forever begin
    @(negedge CLK);
    cyc++;
    chk("req_write", REQ_WRITE, m_req());
    chk("req_write_valid", REQ_WRITE_VALID, m_req());
    chk("out_valid", OUT_VALID, m_q.size() > 0);
    chk("out_data", OUT_DATA, m_q.size() > 0 ? m_q[0] : 32'd0);
    chk("busy", BUSY, m_mode != 0);
    chk("done", DONE, m_done);
    chk("checksum", CHECKSUM, m_csum);
    chk("err", ERR, m_err);
    if (RESET && REQ_WRITE) begin
      req_cnt++;
      req_cyc.push_back(cyc);
    end
    if (DONE) done_cnt++;
    if (OUT_VALID && DEQ) pops.push_back(OUT_DATA);
  end

  // Generator: answers each request one cycle later with index+1.
  int g_idx = 0;
  int g_drop = -1;
  bit g_r;
  bit inject = 0;

  initial forever begin
    @(negedge CLK);
    g_r = REQ_WRITE && RESET;
    @(posedge CLK);
    #1;
    if (g_r) begin
      RESP_READ_VALID = (g_idx != g_drop);
      RESP_READ = 32'(g_idx + 1);
      g_idx++;
    end else begin
      RESP_READ_VALID = inject;
      RESP_READ = inject ? 32'hDEAD_BEEF : 32'd0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_log();
    pops.delete();
    req_cyc.delete();
    req_cnt = 0;
    done_cnt = 0;
    g_idx = 0;
    g_drop = -1;
  endtask

  task automatic wait_done(input string n, input int maxc);
    int k;
    k = 0;
    while (done_cnt == 0 && k < maxc) begin
      tick();
      k++;
    end
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL %s_timeout: no DONE within %0d cycles", n, maxc);
    end
  endtask

  task automatic chk_pops(input string n);
    chk({n, "_len"}, pops.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s_w%0d", n, i),
          i < pops.size() ? pops[i] : 32'hFFFF_FFFF, exp_q[i]);
  endtask

  task automatic burst(input int n);
    START = 1'b1;
    COUNT = CNTW'(n);
    tick();
    START = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_out_data", OUT_DATA, 32'd0);
    chk("rst_busy", BUSY, 1'b0);
    RESET = 1'b1;
    tick();

    // Three back-to-back requests, always popping.
    clear_log();
    GEN_DONE = 1'b1;
    DEQ = 1'b1;
    burst(3);
    wait_done("t1", 40);
    tick();
    exp_q = '{32'd1, 32'd2, 32'd3};
    chk_pops("t1_pops");
    chk("t1_reqs", req_cnt, 3);
    chk("t1_consec", req_cyc.size() == 3 ? req_cyc[2] - req_cyc[0] : -1, 2);
    chk("t1_done", done_cnt, 1);
    chk("t1_csum", CHECKSUM, 32'd0);
    chk("t1_err", ERR, 1'b0);

    // Credit stall with no consumer, then resume.
    clear_log();
    DEQ = 1'b0;
    burst(8);
    repeat (10) tick();
    chk("t2_stall_reqs", req_cnt, 4);
    chk("t2_head", OUT_DATA, 32'd1);
    DEQ = 1'b1;
    wait_done("t2", 60);
    tick();
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
    chk_pops("t2_pops");
    chk("t2_reqs", req_cnt, 8);
    chk("t2_done", done_cnt, 1);
    chk("t2_csum", CHECKSUM, 32'd8);

    // Zero-length burst.
    clear_log();
    burst(0);
    repeat (2) tick();
    chk("t3_reqs", req_cnt, 0);
    chk("t3_done", done_cnt, 1);
    chk("t3_busy", BUSY, 1'b0);

    // Second response dropped.
    clear_log();
    g_drop = 1;
    burst(3);
    wait_done("t4", 40);
    tick();
    exp_q = '{32'd1, 32'd3};
    chk_pops("t4_pops");
    chk("t4_done", done_cnt, 1);
    chk("t4_err", ERR, 1'b1);
    chk("t4_csum", CHECKSUM, 32'd2);
    repeat (3) tick();
    chk("t4_err_sticky", ERR, 1'b1);

    // Reset mid-burst with two words buffered and five remaining.
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    clear_log();
    DEQ = 1'b0;
    GEN_DONE = 1'b1;
    burst(7);
    repeat (2) tick();
    GEN_DONE = 1'b0;
    tick();
    chk("t5_pre_valid", OUT_VALID, 1'b1);
    chk("t5_pre_reqs", req_cnt, 2);
    #2 RESET = 1'b0;
    #1;
    chk("t5_rst_req", REQ_WRITE, 1'b0);
    chk("t5_rst_reqv", REQ_WRITE_VALID, 1'b0);
    chk("t5_rst_ovalid", OUT_VALID, 1'b0);
    chk("t5_rst_odata", OUT_DATA, 32'd0);
    chk("t5_rst_busy", BUSY, 1'b0);
    chk("t5_rst_done", DONE, 1'b0);
    chk("t5_rst_csum", CHECKSUM, 32'd0);
    chk("t5_rst_err", ERR, 1'b0);
    tick();
    tick();
    RESET = 1'b1;
    #2 inject = 1'b1;
    tick();
    #2 inject = 1'b0;
    tick();
    tick();
    chk("t5_stray_err", ERR, 1'b1);
    chk("t5_no_done", done_cnt, 0);
    clear_log();
    GEN_DONE = 1'b1;
    DEQ = 1'b1;
    burst(1);
    wait_done("t5", 30);
    tick();
    exp_q = '{32'd1};
    chk_pops("t5_pops");
    chk("t5_reqs", req_cnt, 1);
    chk("t5_done", done_cnt, 1);

    // Generator not ready for five cycles; START ignored while busy.
    clear_log();
    burst(4);
    tick();
    GEN_DONE = 1'b0;
    START = 1'b1;
    COUNT = CNTW'(9);
    tick();
    START = 1'b0;
    repeat (4) tick();
    chk("t6_gated_reqs", req_cnt, 1);
    GEN_DONE = 1'b1;
    wait_done("t6", 40);
    tick();
    exp_q = '{32'd1, 32'd2, 32'd3, 32'd4};
    chk_pops("t6_pops");
    chk("t6_reqs", req_cnt, 4);
    chk("t6_csum", CHECKSUM, 32'd4);
    chk("t6_done", done_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
